jk_cmd_arbiter: RTL

Round-robin controller that shares one JK flip-flop storage element between `NREQ` requesters. It grants one requester at a time and drives that requester's J/K command onto the shared element for exactly one clock. It then samples the element's `q`, returns the value to the requester and flags any mismatch against the expected JK result. It sits between the requester logic and the single JK cell in the Task1 datapath.

---
 rtl/jk_ctrl_pkg.sv | 21 ++
 rtl/rr_arbiter.sv | 32 +++
 rtl/jk_cmd_arbiter.sv | 104 ++++++++++
 3 files changed

// File: rtl/jk_ctrl_pkg.sv
// jk_ctrl_pkg: shared states, JK command codes and the expected-result helper
package jk_ctrl_pkg;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_DRIVE  = 2'd1,
        S_SAMPLE = 2'd2
    } state_t;

    localparam logic [1:0] CMD_HOLD   = 2'b00;
    localparam logic [1:0] CMD_SET    = 2'b10;
    localparam logic [1:0] CMD_RESET  = 2'b01;
    localparam logic [1:0] CMD_TOGGLE = 2'b11;

    function automatic logic jk_expected(input logic [1:0] cmd, input logic qprev);
        return (cmd == CMD_SET)    ? 1'b1 :
               (cmd == CMD_RESET)  ? 1'b0 :
               (cmd == CMD_TOGGLE) ? ~qprev : qprev;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick starting at the priority pointer
module rr_arbiter #(
    parameter int NREQ = 4,
    localparam int PW = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   pointer,
    input  logic            enable,
    output logic [NREQ-1:0] winner,
    output logic [PW-1:0]   next_pointer
);

    logic [PW-1:0] w_idx;
    logic          w_found;

    // scan from the pointer upward with wrap; first active request wins
    always_comb begin
        winner       = '0;
        next_pointer = pointer;
        w_found      = 1'b0;
        w_idx        = '0;
        for (int i = 0; i < NREQ; i++) begin
            w_idx = PW'((int'(pointer) + i) % NREQ);
            if (enable && !w_found && req[w_idx]) begin
                winner[w_idx] = 1'b1;
                next_pointer  = PW'((int'(w_idx) + 1) % NREQ);
                w_found       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/jk_cmd_arbiter.sv
// jk_cmd_arbiter: round-robin sharing of one JK cell with result check
module jk_cmd_arbiter
    import jk_ctrl_pkg::*;
#(
    parameter int NREQ = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req,
    input  logic [2*NREQ-1:0] cmd,
    input  logic              err_clr,
    input  logic              q,
    output logic              j,
    output logic              k,
    output logic [NREQ-1:0]   gnt,
    output logic              done,
    output logic              rdata,
    output logic              err
);

    localparam int PW = $clog2(NREQ);

    state_t          r_state, w_state_nx;
    logic [PW-1:0]   r_ptr, w_ptr_nx;
    logic [NREQ-1:0] w_winner, r_gnt;
    logic [1:0]      w_win_cmd, r_cmd;
    logic            w_any, w_start, w_mismatch;
    logic            r_qprev, r_rdata, r_err, r_j, r_k, r_done;

    rr_arbiter #(.NREQ(NREQ)) u_arb (
        .req          (req),
        .pointer      (r_ptr),
        .enable       (r_state == S_IDLE),
        .winner       (w_winner),
        .next_pointer (w_ptr_nx)
    );

    assign w_any      = |w_winner;
    assign w_start    = (r_state == S_IDLE) && w_any;
    assign w_mismatch = (r_state == S_SAMPLE) && (q != jk_expected(r_cmd, r_qprev));

    // select the winning requester's command
    always_comb begin
        w_win_cmd = CMD_HOLD;
        for (int i = 0; i < NREQ; i++)
            if (w_winner[i]) w_win_cmd = cmd[2*i +: 2];
    end

    // next state: IDLE -> DRIVE on a grant, then SAMPLE, then back to IDLE
    always_comb begin
        w_state_nx = S_IDLE;
        case (r_state)
            S_IDLE:  w_state_nx = w_any ? S_DRIVE : S_IDLE;
            S_DRIVE: w_state_nx = S_SAMPLE;
            default: w_state_nx = S_IDLE;
        endcase
    end

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nx;
    end

    // grant, command drive, capture and sticky error registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr   <= '0;
            r_gnt   <= '0;
            r_cmd   <= CMD_HOLD;
            r_qprev <= 1'b0;
            r_j     <= 1'b0;
            r_k     <= 1'b0;
            r_done  <= 1'b0;
            r_rdata <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_j    <= w_start ? w_win_cmd[1] : 1'b0;
            r_k    <= w_start ? w_win_cmd[0] : 1'b0;
            r_done <= (r_state == S_DRIVE);
            if (r_state == S_IDLE)
                r_gnt <= w_winner;
            else if (r_state == S_SAMPLE)
                r_gnt <= '0;
            if (w_start) begin
                r_ptr   <= w_ptr_nx;
                r_cmd   <= w_win_cmd;
                r_qprev <= q;
            end
            if (r_state == S_SAMPLE)
                r_rdata <= q;
            r_err <= err_clr ? 1'b0 : (r_err | w_mismatch);
        end
    end

    assign j    = r_j;
    assign k    = r_k;
    assign gnt  = r_gnt;
    assign done = r_done;
    assign err  = r_err;
    // the cell only settles on the edge entering SAMPLE, so q is forwarded while done is high and held afterwards
    assign rdata = (r_state == S_SAMPLE) ? q : r_rdata;

endmodule
